// File: rtl/alu_div_pkg.sv
// Shared definitions for the multi-cycle DIV/REM unit.
//   div_state_e  : sequencer states of the iterative divider
//   div_spec_e   : special-result class decided during SETUP
//   most_neg()   : most-negative two's-complement value for a given width
package alu_div_pkg;

  localparam int unsigned DIV_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ITER,
    FIX
  } div_state_e;

  typedef enum logic [1:0] {
    SPEC_NONE,
    SPEC_DIVZERO,
    SPEC_OVF
  } div_spec_e;

  // Valid for widths up to 64; callers truncate to their own width.
  function automatic logic [63:0] most_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/iterative_division_if.sv
// Request/result bundle between the ALU control and the iterative divider.
//   master : issues Start/Signed/Min/Div, observes Busy/Done and results
//   slave  : the divider itself
interface iterative_division_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] Min;
  logic [WIDTH-1:0] Div;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             HasRemainder;
  logic             DivByZero;
  logic             Overflow;

  modport master (
    output Start, Signed, Min, Div,
    input  Busy, Done, Quotient, Remainder, HasRemainder, DivByZero, Overflow
  );

  modport slave (
    input  Start, Signed, Min, Div,
    output Busy, Done, Quotient, Remainder, HasRemainder, DivByZero, Overflow
  );

endinterface

// File: rtl/division_step.sv
// One restoring radix-2 division step (combinational).
//   rem_i : current partial remainder (always < divisor)
//   div_i : divisor magnitude
//   bit_i : next dividend bit shifted in
//   rem_o : next partial remainder
//   q_o   : produced quotient bit
module division_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  // Shifted remainder needs one extra bit so the compare cannot wrap.
  logic [WIDTH:0] p;

  always_comb begin
    p     = {rem_i, bit_i};
    q_o   = (p >= {1'b0, div_i});
    // After a successful subtract the result is below div_i, so it fits WIDTH bits.
    rem_o = q_o ? (p[WIDTH-1:0] - div_i) : p[WIDTH-1:0];
  end

endmodule

// File: rtl/iterative_division.sv
// Multi-cycle signed/unsigned restoring divider (one quotient bit per clock).
//   Clk   : rising-edge clock
//   Reset : asynchronous active-high reset, discards any operation in flight
//   bus   : slave side of iterative_division_if
//           Start/Signed/Min/Div in; Busy, Done pulse, Quotient, Remainder,
//           HasRemainder, DivByZero, Overflow out (all registered)
// Divide-by-zero returns all-ones / dividend; signed overflow returns
// dividend / zero. Quotient truncates toward zero, remainder follows the
// dividend's sign.
module iterative_division
  import alu_div_pkg::*;
#(
  parameter  int unsigned WIDTH = DIV_DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input logic                 Clk,
  input logic                 Reset,
  iterative_division_if.slave bus
);

  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

  div_state_e       state_q;
  div_spec_e        spec_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] min_q, div_q;
  logic             sgn_q;
  logic [WIDTH-1:0] q_q, r_q, d_q;
  logic             qneg_q, rneg_q;

  logic             busy_q, done_q, has_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH-1:0] min_abs, div_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] fix_quot, fix_rem;

  division_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (r_q),
    .div_i (d_q),
    .bit_i (q_q[WIDTH-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    min_abs = (sgn_q && min_q[WIDTH-1]) ? (-min_q) : min_q;
    div_abs = (sgn_q && div_q[WIDTH-1]) ? (-div_q) : div_q;

    fix_quot = qneg_q ? (-q_q) : q_q;
    fix_rem  = rneg_q ? (-r_q) : r_q;
    case (spec_q)
      SPEC_DIVZERO: begin
        fix_quot = '1;
        fix_rem  = min_q;
      end
      SPEC_OVF: begin
        fix_quot = min_q;
        fix_rem  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      spec_q  <= SPEC_NONE;
      cnt_q   <= '0;
      min_q   <= '0;
      div_q   <= '0;
      sgn_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      has_q   <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            min_q   <= bus.Min;
            div_q   <= bus.Div;
            sgn_q   <= bus.Signed;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (div_q == '0) begin
            spec_q  <= SPEC_DIVZERO;
            state_q <= FIX;
          end else if (sgn_q && (min_q == MOST_NEG) && (div_q == '1)) begin
            spec_q  <= SPEC_OVF;
            state_q <= FIX;
          end else begin
            spec_q  <= SPEC_NONE;
            q_q     <= min_abs;
            d_q     <= div_abs;
            qneg_q  <= sgn_q & (min_q[WIDTH-1] ^ div_q[WIDTH-1]);
            rneg_q  <= sgn_q & min_q[WIDTH-1];
            r_q     <= '0;
            cnt_q   <= CNT_W'(WIDTH - 1);
            state_q <= ITER;
          end
        end
        ITER: begin
          // q_q doubles as the dividend shift register: its MSB feeds the step
          // while quotient bits enter at the LSB.
          q_q <= {q_q[WIDTH-2:0], step_q};
          r_q <= step_rem;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FIX: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          quot_q  <= fix_quot;
          rem_q   <= fix_rem;
          has_q   <= |fix_rem;
          dbz_q   <= (spec_q == SPEC_DIVZERO);
          ovf_q   <= (spec_q == SPEC_OVF);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;
  assign bus.Quotient     = quot_q;
  assign bus.Remainder    = rem_q;
  assign bus.HasRemainder = has_q;
  assign bus.DivByZero    = dbz_q;
  assign bus.Overflow     = ovf_q;

endmodule

// File: tb/tb_iterative_division.sv
// Directed self-checking bench for iterative_division (WIDTH=16).
module tb_iterative_division;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  iterative_division_if #(.WIDTH(16)) bus ();

  iterative_division #(.WIDTH(16)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents a request, lets edge k accept it.
  task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b, input string tag);
    bus.Start  = 1'b1;
    bus.Signed = s;
    bus.Min    = a;
    bus.Div    = b;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    chk({tag, ".busy"}, 32'(bus.Busy), 32'd1);
    chk({tag, ".done_lo"}, 32'(bus.Done), 32'd0);
  endtask

  // Counts edges since acceptance until Done; optional stray Start at poke.
  // Returns at the negedge of the Done cycle.
  task automatic await_done(input int lat, input int poke,
                            input logic [15:0] eq, input logic [15:0] er,
                            input logic eh, input logic ez, input logic eo,
                            input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (poke > 0 && n == poke) begin
        bus.Start  = 1'b1;
        bus.Signed = 1'b0;
        bus.Min    = 16'h0001;
        bus.Div    = 16'h0001;
      end else begin
        bus.Start = 1'b0;
      end
    end while (!bus.Done && n < 200);
    bus.Start = 1'b0;
    chk({tag, ".latency"}, 32'(n), 32'(lat));
    chk({tag, ".quot"}, 32'(bus.Quotient), 32'(eq));
    chk({tag, ".rem"}, 32'(bus.Remainder), 32'(er));
    chk({tag, ".hasrem"}, 32'(bus.HasRemainder), 32'(eh));
    chk({tag, ".dbz"}, 32'(bus.DivByZero), 32'(ez));
    chk({tag, ".ovf"}, 32'(bus.Overflow), 32'(eo));
    chk({tag, ".busy_lo"}, 32'(bus.Busy), 32'd0);
  endtask

  task automatic after_done(input string tag, input logic [15:0] eq);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(bus.Done), 32'd0);
    chk({tag, ".idle"}, 32'(bus.Busy), 32'd0);
    chk({tag, ".hold"}, 32'(bus.Quotient), 32'(eq));
  endtask

  task automatic run(input logic s, input logic [15:0] a, input logic [15:0] b, input int lat,
                     input logic [15:0] eq, input logic [15:0] er,
                     input logic eh, input logic ez, input logic eo, input string tag);
    @(negedge clk);
    launch(s, a, b, tag);
    await_done(lat, 0, eq, er, eh, ez, eo, tag);
    after_done(tag, eq);
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.Signed = 1'b0;
    bus.Min    = '0;
    bus.Div    = '0;
    #12;
    chk("rst.busy", 32'(bus.Busy), 32'd0);
    chk("rst.done", 32'(bus.Done), 32'd0);
    chk("rst.quot", 32'(bus.Quotient), 32'd0);
    chk("rst.rem", 32'(bus.Remainder), 32'd0);
    chk("rst.flags", {29'd0, bus.HasRemainder, bus.DivByZero, bus.Overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    //  s     Min       Div      lat  Quot      Rem       H     Z     O
    run(1'b0, 16'd18,   16'd4,   18, 16'd4,    16'd2,    1'b1, 1'b0, 1'b0, "u18_4");
    run(1'b0, 16'd18,   16'd3,   18, 16'd6,    16'd0,    1'b0, 1'b0, 1'b0, "u18_3");
    run(1'b0, 16'd0,    16'd0,   2,  16'hFFFF, 16'd0,    1'b0, 1'b1, 1'b0, "u0_0");
    run(1'b0, 16'd7,    16'd0,   2,  16'hFFFF, 16'd7,    1'b1, 1'b1, 1'b0, "u7_0");
    run(1'b1, 16'hFFF9, 16'h0002, 18, 16'hFFFD, 16'hFFFF, 1'b1, 1'b0, 1'b0, "sm7_2");
    run(1'b1, 16'h0007, 16'hFFFE, 18, 16'hFFFD, 16'h0001, 1'b1, 1'b0, 1'b0, "s7_m2");
    run(1'b1, 16'hFFF8, 16'hFFFD, 18, 16'h0002, 16'hFFFE, 1'b1, 1'b0, 1'b0, "sm8_m3");
    run(1'b1, 16'h8000, 16'hFFFF, 2,  16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, "s_ovf");
    run(1'b0, 16'h8000, 16'hFFFF, 18, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0, "u_8000");

    // Stray Start mid-operation must be ignored.
    @(negedge clk);
    launch(1'b0, 16'd100, 16'd7, "poke");
    await_done(18, 5, 16'd14, 16'd2, 1'b1, 1'b0, 1'b0, "poke");
    after_done("poke", 16'd14);

    // Start during the Done cycle is accepted with no bubble.
    @(negedge clk);
    launch(1'b0, 16'hFFFF, 16'd256, "b2b_a");
    await_done(18, 0, 16'd255, 16'd255, 1'b1, 1'b0, 1'b0, "b2b_a");
    launch(1'b1, 16'hFF9C, 16'd7, "b2b_b");
    await_done(18, 0, 16'hFFF2, 16'hFFFE, 1'b1, 1'b0, 1'b0, "b2b_b");
    after_done("b2b_b", 16'hFFF2);

    // Reset in the middle of an operation.
    @(negedge clk);
    launch(1'b0, 16'd1000, 16'd3, "rstmid");
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid.busy", 32'(bus.Busy), 32'd0);
    chk("rstmid.done", 32'(bus.Done), 32'd0);
    chk("rstmid.quot", 32'(bus.Quotient), 32'd0);
    chk("rstmid.rem", 32'(bus.Remainder), 32'd0);
    chk("rstmid.flags", {29'd0, bus.HasRemainder, bus.DivByZero, bus.Overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.Done || bus.Busy) seen++;
    end
    chk("rstmid.no_done", 32'(seen), 32'd0);

    run(1'b1, 16'h8000, 16'h0002, 18, 16'hC000, 16'h0000, 1'b0, 1'b0, 1'b0, "s_neg_2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_division.md
Name: iterative_division

Overview:
- Sequential, parametrised successor to the team's combinational divider.
- Restoring radix-2 division, one quotient bit per clock.
- Adds signed/unsigned mode, full remainder output, a start/done handshake, and RISC-V-style divide-by-zero and signed-overflow results.
- Sits in the ALU as the multi-cycle DIV/REM unit; the control unit stalls on Busy.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH), iteration-counter width (derived, not overridden).

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request; sampled only when Busy=0
- Signed  input  1  1 = two's-complement operands, 0 = unsigned
- Min  input  WIDTH  dividend (minuend), captured on accepted Start
- Div  input  WIDTH  divisor, captured on accepted Start
- Busy  output  1  high from the edge after an accepted Start until Done
- Done  output  1  one-cycle pulse; results valid from this cycle
- Quotient  output  WIDTH  registered quotient
- Remainder  output  WIDTH  registered remainder
- HasRemainder  output  1  Remainder != 0
- DivByZero  output  1  Div was 0
- Overflow  output  1  Signed=1, Min=most-negative, Div=-1

Behaviour:
- Reset (async, any state): state=IDLE; Busy, Done, Quotient, Remainder, HasRemainder, DivByZero, Overflow all 0; counter 0. Reset mid-operation discards the operation. No Done is issued for it.
- States: IDLE, SETUP, ITER, FIX.
- IDLE:
  - Start=1 at edge k: latch Min, Div, Signed; go to SETUP; Busy=1 from edge k.
  - Start=0: stay in IDLE.
- SETUP (1 cycle):
  - Div==0: set the special flag and go to FIX.
  - Signed & Min==1<<(WIDTH-1) & Div==all-ones: set the special flag and go to FIX.
  - Otherwise: register |Min| and |Div| (when Signed=1), record the quotient sign (sign(Min) XOR sign(Div)) and the remainder sign (sign(Min)). Clear the partial remainder, set counter=WIDTH-1, go to ITER.
- ITER (WIDTH cycles), each cycle:
  - P = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifted left.
  - If P >= D: R = P - D and Q[0]=1; else R = P and Q[0]=0.
  - Partial remainder is WIDTH+1 bits internally to avoid compare overflow.
  - Counter decrements; at 0, go to FIX.
- FIX (1 cycle), then IDLE:
  - Outputs written at the FIX edge: Done=1, Busy=0.
  - Normal: Quotient = negate-if-sign(Q), Remainder = negate-if-sign(R). Remainder takes the dividend's sign; quotient truncates toward zero.
  - Div==0: Quotient = all-ones, Remainder = Min, DivByZero=1.
  - Overflow case: Quotient = Min, Remainder = 0, Overflow=1.
  - HasRemainder = |Remainder.
- Latency, Start at edge k:
  - Normal: Done high after edge k+WIDTH+2 (k+18 for WIDTH=16).
  - Special cases: Done high after edge k+2.
- Done lasts exactly one cycle.
- Quotient, Remainder and flags hold until the FIX of the next operation. They do not clear on Start.
- Start while Busy=1: ignored, no queuing.
- Start during the Done cycle is accepted (Busy=0 then), so back-to-back operation has no bubble.
- DivByZero and Overflow are never both set.
- Signed=0 with MSB-set operands is treated as plain unsigned magnitudes.

Decomposition:
- Shared package alu_div_pkg: state enum (IDLE, SETUP, ITER, FIX) and a localparam for the most-negative value helper.
- One sub-module, division_step: combinational single restoring step. Inputs: partial remainder, divisor, incoming dividend bit. Outputs: next remainder and quotient bit. Instantiated once inside ITER.
- Negation and abs logic stays in the top level.

Test Plan (WIDTH=16):
- Unsigned 18/4, Start at edge k -> Done at k+18; Quotient=4, Remainder=2, HasRemainder=1, DivByZero=0, Overflow=0.
- Unsigned 18/3 -> Quotient=6, Remainder=0, HasRemainder=0. Unsigned 0/0 -> Done at k+2; Quotient=0xFFFF, Remainder=0, DivByZero=1.
- Unsigned 7/0 -> Done at k+2; Quotient=0xFFFF, Remainder=7, DivByZero=1, HasRemainder=1.
- Signed -7/2 (0xFFF9/0x0002) -> Quotient=0xFFFD (-3), Remainder=0xFFFF (-1). Signed 7/-2 -> Quotient=0xFFFD, Remainder=1.
- Signed 0x8000/0xFFFF -> Done at k+2; Quotient=0x8000, Remainder=0, Overflow=1. The same operands with Signed=0 -> Quotient=0, Remainder=0x8000, 18-cycle latency.
- Handshake and reset:
  - Start pulsed mid-operation -> ignored; a single Done; results unchanged.
  - Start in the Done cycle -> next Done exactly 18 cycles later.
  - Reset asserted at cycle 5 of an operation -> all outputs 0 immediately, no Done; a new Start afterwards completes normally.
